event_encoder_8to3: RTL and testbench

- Sequential 8-line to 3-bit event encoder; the transmit-side counterpart of the 3-to-8 line decoder.
- Captures rising edges on 8 request lines into sticky pending bits.
- Emits one 3-bit code per captured event over a valid/ready handshake.
- The code uses the same line-to-code mapping the decoder inverts, so decoding code_o reproduces the one-hot line that raised the event.

---
 rtl/event_encoder_8to3.sv | 107 ++++++++++
 tb/tb_event_encoder_8to3.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/event_encoder_8to3.sv
// event_encoder_8to3: sequential 8-line to 3-bit event encoder.
// Rising edges on request_i are captured into sticky pending bits. Each
// pending event is emitted once as a 3-bit code over a valid/ready handshake.
// The code for line k is {~k[2], k[1], k[0]}, which the matching 3-to-8
// decoder turns back into the one-hot line that raised the event.
//
// Handshake: valid_o/code_o are held stable until the consumer accepts them.
// A transfer happens on any rising clk_i edge where valid_o & ready_i.
// While valid_o=0, ready_i is ignored.
//
// The FSM state is observable on valid_o: IDLE drives 0 and SEND drives 1.
module event_encoder_8to3 #(
    parameter bit HIGH_FIRST = 1'b1  // 1: highest pending index wins, 0: lowest wins
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] request_i,
    input  logic       clear_i,
    output logic [2:0] code_o,
    output logic       valid_o,
    input  logic       ready_i,
    output logic [7:0] pending_o,
    output logic       overflow_o
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] req_q;
    logic [7:0] rise;
    logic [7:0] pending_q, pending_d;
    logic [7:0] grant_onehot;
    logic [2:0] sel;
    logic [2:0] code_q, code_d;
    logic       overflow_q, overflow_d;
    logic       take;

    // Edge detect against the previous-cycle request value.
    assign rise = request_i & ~req_q;

    // Arbitration: choose one pending line according to HIGH_FIRST.
    // This uses only the registered pending bits, so a rise is never
    // granted on the same edge that captures it.
    always_comb begin
        sel = 3'd0;
        if (HIGH_FIRST) begin
            for (int i = 0; i < 8; i++) begin
                if (pending_q[i]) sel = 3'(i);
            end
        end else begin
            for (int i = 7; i >= 0; i--) begin
                if (pending_q[i]) sel = 3'(i);
            end
        end
    end

    // A grant happens from IDLE, or from SEND when the held code is accepted.
    assign take         = (pending_q != 8'h00) && ((state_q == IDLE) || ready_i);
    assign grant_onehot = take ? (8'b1 << sel) : 8'h00;

    // Next-state, next-code, pending and overflow update.
    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        if (take) begin
            code_d  = {~sel[2], sel[1:0]};
            state_d = SEND;
        end else if ((state_q == SEND) && ready_i) begin
            state_d = IDLE;
        end

        // A rise on the line granted in this edge is a new event, not a loss.
        if (clear_i) begin
            pending_d  = rise;
            overflow_d = 1'b0;
        end else begin
            pending_d  = (pending_q & ~grant_onehot) | rise;
            overflow_d = overflow_q | (|(rise & pending_q & ~grant_onehot));
        end
    end

    // State, code, pending, overflow and request-history registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            code_q     <= 3'b000;
            pending_q  <= 8'h00;
            overflow_q <= 1'b0;
            req_q      <= 8'h00;
        end else begin
            state_q    <= state_d;
            code_q     <= code_d;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
            req_q      <= request_i;
        end
    end

    assign code_o     = code_q;
    assign valid_o    = (state_q == SEND);
    assign pending_o  = pending_q;
    assign overflow_o = overflow_q;

endmodule

// File: tb/tb_event_encoder_8to3.sv
// Testbench for event_encoder_8to3: table of per-cycle vectors plus a
// hand-written asynchronous reset sequence. A HIGH_FIRST=1 and a
// HIGH_FIRST=0 instance share all inputs.
module tb_event_encoder_8to3;

    logic       clk;
    logic       rst;
    logic [7:0] request;
    logic       clear;
    logic       ready;

    logic [2:0] code_hi, code_lo;
    logic       valid_hi, valid_lo;
    logic [7:0] pending_hi, pending_lo;
    logic       overflow_hi, overflow_lo;

    int n_checks = 0;
    int n_pass   = 0;

    event_encoder_8to3 #(.HIGH_FIRST(1'b1)) dut_hi (
        .clk_i     (clk),
        .rst_i     (rst),
        .request_i (request),
        .clear_i   (clear),
        .code_o    (code_hi),
        .valid_o   (valid_hi),
        .ready_i   (ready),
        .pending_o (pending_hi),
        .overflow_o(overflow_hi)
    );

    event_encoder_8to3 #(.HIGH_FIRST(1'b0)) dut_lo (
        .clk_i     (clk),
        .rst_i     (rst),
        .request_i (request),
        .clear_i   (clear),
        .code_o    (code_lo),
        .valid_o   (valid_lo),
        .ready_i   (ready),
        .pending_o (pending_lo),
        .overflow_o(overflow_lo)
    );

    // Clock: 10 time-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] req;
        logic       rdy;
        logic       clr;
        logic       exp_valid;
        logic [2:0] exp_code;
        logic [7:0] exp_pend;
        logic       exp_ovf;
        logic       chk_lo;
        logic [2:0] exp_code_lo;
        logic [7:0] exp_pend_lo;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [7:0] req, input logic rdy, input logic clr,
                       input logic v, input logic [2:0] c, input logic [7:0] p,
                       input logic o, input logic chk, input logic [2:0] cl,
                       input logic [7:0] pl);
        vec_t e;
        e.req = req; e.rdy = rdy; e.clr = clr;
        e.exp_valid = v; e.exp_code = c; e.exp_pend = p; e.exp_ovf = o;
        e.chk_lo = chk; e.exp_code_lo = cl; e.exp_pend_lo = pl;
        vecs.push_back(e);
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; request = 8'h00; clear = 1'b0; ready = 1'b1;

        // Reset release, idle for 5 cycles.
        for (int i = 0; i < 5; i++) add(8'h00,1,0, 0,3'd0,8'h00,0, 1,3'd0,8'h00);
        // Single line 0 event, held high afterwards.
        add(8'h01,1,0, 0,3'd0,8'h01,0, 1,3'd0,8'h01);
        add(8'h01,1,0, 1,3'd4,8'h00,0, 1,3'd4,8'h00);
        add(8'h01,1,0, 0,3'd4,8'h00,0, 1,3'd4,8'h00);
        add(8'h01,1,0, 0,3'd4,8'h00,0, 1,3'd4,8'h00);
        add(8'h00,1,0, 0,3'd4,8'h00,0, 1,3'd4,8'h00);
        // Lines 7,4,0 together: opposite orders in the two instances.
        add(8'h91,1,0, 0,3'd4,8'h91,0, 1,3'd4,8'h91);
        add(8'h91,1,0, 1,3'd3,8'h11,0, 1,3'd4,8'h90);
        add(8'h91,1,0, 1,3'd0,8'h01,0, 1,3'd0,8'h80);
        add(8'h91,1,0, 1,3'd4,8'h00,0, 1,3'd3,8'h00);
        add(8'h91,1,0, 0,3'd4,8'h00,0, 1,3'd3,8'h00);
        add(8'h00,1,0, 0,3'd4,8'h00,0, 1,3'd3,8'h00);
        // Line 2 held with ready low; line 5 pulsed twice -> overflow.
        add(8'h04,0,0, 0,3'd4,8'h04,0, 0,3'd0,8'h00);
        add(8'h04,0,0, 1,3'd6,8'h00,0, 0,3'd0,8'h00);
        add(8'h04,0,0, 1,3'd6,8'h00,0, 0,3'd0,8'h00);
        add(8'h24,0,0, 1,3'd6,8'h20,0, 0,3'd0,8'h00);
        add(8'h04,0,0, 1,3'd6,8'h20,0, 0,3'd0,8'h00);
        add(8'h24,0,0, 1,3'd6,8'h20,1, 0,3'd0,8'h00);
        for (int i = 0; i < 6; i++) add(8'h04,0,0, 1,3'd6,8'h20,1, 0,3'd0,8'h00);
        add(8'h04,1,0, 1,3'd1,8'h00,1, 0,3'd0,8'h00);
        add(8'h04,1,0, 0,3'd1,8'h00,1, 0,3'd0,8'h00);
        add(8'h00,1,0, 0,3'd1,8'h00,1, 0,3'd0,8'h00);
        // Clear in SEND with pending 06 and a rise on line 6.
        add(8'h01,0,0, 0,3'd1,8'h01,1, 0,3'd0,8'h00);
        add(8'h01,0,0, 1,3'd4,8'h00,1, 0,3'd0,8'h00);
        add(8'h07,0,0, 1,3'd4,8'h06,1, 0,3'd0,8'h00);
        add(8'h47,0,1, 1,3'd4,8'h40,0, 0,3'd0,8'h00);
        // Line 3 re-rises on the edge that grants it: new event, no overflow.
        add(8'h4F,0,0, 1,3'd4,8'h48,0, 0,3'd0,8'h00);
        add(8'h47,0,0, 1,3'd4,8'h48,0, 0,3'd0,8'h00);
        add(8'h47,1,0, 1,3'd2,8'h08,0, 0,3'd0,8'h00);
        add(8'h4F,1,0, 1,3'd7,8'h08,0, 0,3'd0,8'h00);
        add(8'h4F,1,0, 1,3'd7,8'h00,0, 0,3'd0,8'h00);
        add(8'h4F,1,0, 0,3'd7,8'h00,0, 0,3'd0,8'h00);
        add(8'h00,1,0, 0,3'd7,8'h00,0, 0,3'd0,8'h00);

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        foreach (vecs[i]) begin
            request = vecs[i].req;
            ready   = vecs[i].rdy;
            clear   = vecs[i].clr;
            step();
            check($sformatf("v%0d valid", i), {7'd0, valid_hi}, {7'd0, vecs[i].exp_valid});
            check($sformatf("v%0d code", i), {5'd0, code_hi}, {5'd0, vecs[i].exp_code});
            check($sformatf("v%0d pending", i), pending_hi, vecs[i].exp_pend);
            check($sformatf("v%0d overflow", i), {7'd0, overflow_hi}, {7'd0, vecs[i].exp_ovf});
            if (vecs[i].chk_lo) begin
                check($sformatf("v%0d lo valid", i), {7'd0, valid_lo}, {7'd0, vecs[i].exp_valid});
                check($sformatf("v%0d lo code", i), {5'd0, code_lo}, {5'd0, vecs[i].exp_code_lo});
                check($sformatf("v%0d lo pending", i), pending_lo, vecs[i].exp_pend_lo);
            end
        end
        clear = 1'b0;

        // Asynchronous reset in the middle of a SEND on line 6.
        request = 8'h40; ready = 1'b0;
        step();
        check("ar pending", pending_hi, 8'h40);
        step();
        check("ar valid", {7'd0, valid_hi}, 8'h01);
        check("ar code", {5'd0, code_hi}, 8'h02);
        #3 rst = 1'b1;
        #1;
        check("ar rst valid", {7'd0, valid_hi}, 8'h00);
        check("ar rst code", {5'd0, code_hi}, 8'h00);
        check("ar rst pending", pending_hi, 8'h00);
        check("ar rst overflow", {7'd0, overflow_hi}, 8'h00);
        check("ar rst lo valid", {7'd0, valid_lo}, 8'h00);
        check("ar rst lo pending", pending_lo, 8'h00);
        step();
        rst = 1'b0;
        // Line 6 is still high at release: it counts as an edge on the first clock.
        step();
        check("rel pending", pending_hi, 8'h40);
        check("rel valid", {7'd0, valid_hi}, 8'h00);
        step();
        check("rel grant valid", {7'd0, valid_hi}, 8'h01);
        check("rel grant code", {5'd0, code_hi}, 8'h02);
        check("rel grant pending", pending_hi, 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
